imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It takes a byte stream, for example from a UART receiver, and parses it as a framed program image. It assembles big-endian 32-bit instruction words and writes them into instruction memory at consecutive byte addresses, matching the processor's PC stride of 4. While loading, it holds the processor in reset and releases it only after a frame whose checksum verifies.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// The master modport is the stream source and memory side; the slave is the loader.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream into big-endian words, writes them
// to instruction memory and releases the core only after a verified checksum.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus,
    output logic          cpu_reset_n,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);
    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, DATA, CSUM, DONE, ERROR
    } state_t;

    localparam logic [16:0] MAXW = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic        live;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [15:0] cnt_q;
    logic [7:0]  xsum_q;
    logic [23:0] word_q;
    logic [1:0]  bidx_q;
    logic [15:0] wl_q;

    logic        take;
    logic        waiting;
    logic        start;
    logic        word_end;
    logic [15:0] cnt_full;

    assign take     = bus.in_valid & bus.in_ready;
    assign waiting  = (state_q == IDLE) || (state_q == DONE) ||
                      (state_q == ERROR);
    assign start    = waiting && take && (bus.in_data == 8'hA5);
    assign word_end = take && (state_q == DATA) && (bidx_q == 2'd3);
    assign cnt_full = {cnt_q[15:8], bus.in_data};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) state_d = CNT_HI;
            end
            CNT_HI: begin
                if (take) state_d = CNT_LO;
            end
            CNT_LO: begin
                if (take) begin
                    if ({1'b0, cnt_full} > MAXW) state_d = ERROR;
                    else if (cnt_full == 16'd0)  state_d = CSUM;
                    else                         state_d = DATA;
                end
            end
            DATA: begin
                if (word_end && (wl_q + 16'd1 == cnt_q)) state_d = CSUM;
            end
            CSUM: begin
                if (take) begin
                    state_d = (bus.in_data == xsum_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            cnt_q   <= 16'd0;
            xsum_q  <= 8'd0;
            word_q  <= 24'd0;
            bidx_q  <= 2'd0;
            wl_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            live    <= 1'b1;
            we_q    <= 1'b0;
            if (start) begin
                xsum_q <= 8'd0;
                wl_q   <= 16'd0;
                bidx_q <= 2'd0;
            end else if (take) begin
                unique case (state_q)
                    CNT_HI: begin
                        cnt_q[15:8] <= bus.in_data;
                        xsum_q      <= xsum_q ^ bus.in_data;
                    end
                    CNT_LO: begin
                        cnt_q[7:0] <= bus.in_data;
                        xsum_q     <= xsum_q ^ bus.in_data;
                    end
                    DATA: begin
                        word_q <= {word_q[15:0], bus.in_data};
                        xsum_q <= xsum_q ^ bus.in_data;
                        bidx_q <= bidx_q + 2'd1;
                        if (bidx_q == 2'd3) begin
                            we_q    <= 1'b1;
                            wdata_q <= {word_q, bus.in_data};
                            addr_q  <= BASE_ADDR + {14'd0, wl_q, 2'b00};
                            wl_q    <= wl_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // One back-pressure cycle per word: no byte is taken while the write issues.
    assign bus.in_ready  = live & ~we_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign done          = (state_q == DONE);
    assign cpu_reset_n   = (state_q == DONE);
    assign error         = (state_q == ERROR);
    assign words_loaded  = wl_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame vector table, scoreboard of expected writes,
// and hand sequences for reset, oversize count and reload.
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    int          total = 0;
    int          bad = 0;
    bit          chk_rdy = 1'b0;
    logic [63:0] exp_q[$];

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .cpu_reset_n(cpu_reset_n),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Write monitor: pops one expected {addr,data} per mem_we cycle.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            chk("ready_low_in_write", 32'(bus.in_ready), 32'd0);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%h/%h want=none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL write got=%h/%h want=%h/%h",
                             bus.mem_addr, bus.mem_wdata, e[63:32], e[31:0]);
                end
            end
        end else if (chk_rdy) begin
            chk("ready_high", 32'(bus.in_ready), 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            rdy = bus.in_ready;
            @(negedge clk);
            if (rdy) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int n, input bit badsum, input int gap);
        logic [7:0]  xs;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] c;
        c  = 16'(n);
        xs = c[15:8] ^ c[7:0];
        send_byte(8'hA5);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                b  = w[31 - 8*j -: 8];
                xs = xs ^ b;
                if (j == 3) exp_q.push_back({BASE + 32'(4*i), w});
                if (gap > 0 && j == 2) idle(gap);
                send_byte(b);
            end
        end
        send_byte(badsum ? (xs ^ 8'h5A) : xs);
    endtask

    typedef struct {
        int n;
        bit badsum;
        int gap;
        bit exp_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n: 3, badsum: 1'b0, gap: 3, exp_done: 1'b1};
        tbl[1] = '{n: 2, badsum: 1'b1, gap: 0, exp_done: 1'b0};
        tbl[2] = '{n: 5, badsum: 1'b0, gap: 0, exp_done: 1'b1};
        tbl[3] = '{n: 4, badsum: 1'b1, gap: 1, exp_done: 1'b0};
        tbl[4] = '{n: 0, badsum: 1'b0, gap: 0, exp_done: 1'b1};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        #3;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, BASE);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_cpu", 32'(cpu_reset_n), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rdy = 1'b1;

        // One-word frame with hand-computed checksum.
        exp_q.push_back({BASE, 32'h12345678});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        send_byte(8'h78);
        chk("one_cpu_before", 32'(cpu_reset_n), 32'd0);
        send_byte(8'h09);
        chk("one_done", 32'(done), 32'd1);
        chk("one_cpu", 32'(cpu_reset_n), 32'd1);
        chk("one_wl", 32'(words_loaded), 32'd1);
        chk("one_q", 32'(exp_q.size()), 32'd0);

        // Reload from DONE: cpu_reset_n drops right after the 0xA5.
        send_byte(8'hA5);
        chk("reload_cpu", 32'(cpu_reset_n), 32'd0);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_wl", 32'(words_loaded), 32'd0);
        exp_q.push_back({BASE, 32'hDEADBEEF});
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
        chk("reload_done2", 32'(done), 32'd1);

        foreach (tbl[i]) begin
            send_frame(tbl[i].n, tbl[i].badsum, tbl[i].gap);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].exp_done));
            chk($sformatf("v%0d_cpu", i), 32'(cpu_reset_n),
                32'(tbl[i].exp_done));
            chk($sformatf("v%0d_err", i), 32'(error), 32'(!tbl[i].exp_done));
            chk($sformatf("v%0d_wl", i), 32'(words_loaded), 32'(tbl[i].n));
            idle(2);
            chk($sformatf("v%0d_q", i), 32'(exp_q.size()), 32'd0);
        end

        // Oversized count: rejected right after CNT_LO, nothing written.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        chk("big_err", 32'(error), 32'd1);
        chk("big_done", 32'(done), 32'd0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        chk("big_err_hold", 32'(error), 32'd1);
        chk("big_wl", 32'(words_loaded), 32'd0);

        // Count 256 is the largest accepted frame boundary.
        send_frame(256, 1'b0, 0);
        chk("max_done", 32'(done), 32'd1);
        chk("max_wl", 32'(words_loaded), 32'd256);

        // Asynchronous reset after two data bytes.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        chk_rdy = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_cpu", 32'(cpu_reset_n), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(error), 32'd0);
        chk("mid_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_addr", bus.mem_addr, BASE);
        chk("mid_wdata", bus.mem_wdata, 32'd0);
        chk("mid_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_rdy = 1'b1;
        send_byte(8'h33); send_byte(8'h00); send_byte(8'h7E);
        chk("garbage_done", 32'(done), 32'd0);
        send_frame(2, 1'b0, 0);
        chk("after_rst_done", 32'(done), 32'd1);
        chk("after_rst_wl", 32'(words_loaded), 32'd2);
        idle(3);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
